// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin arbiter that time-shares one combinational ALU between NREQ requesters.
// Optional ALU_SHARE_DIVZERO_GUARD_EN adds a div_zero output; it also makes mod-by-zero bypass the ALU.
module alu_share_arbiter #(
  parameter int N        = 32,
  parameter int NREQ     = 2,
  parameter int FAST_LAT = 1,
  parameter int SLOW_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] req_opcode,
  input  logic [N*NREQ-1:0] req_a,
  input  logic [N*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   ack,
  output logic [N-1:0]      result,
  output logic              carryout,
  output logic [2:0]        grant_id,
  output logic              busy,
  output logic [2:0]        alu_opcode,
  output logic [N-1:0]      alu_a,
  output logic [N-1:0]      alu_b,
  input  logic [N-1:0]      alu_result,
  input  logic              alu_carryout
`ifdef ALU_SHARE_DIVZERO_GUARD_EN
  ,
  output logic              div_zero
`endif
);
  localparam int MAXLAT = (FAST_LAT > SLOW_LAT) ? FAST_LAT : SLOW_LAT;
  localparam int CW = $clog2(MAXLAT + 1);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  logic [2:0]      gid_q, gid_d;
  logic [2:0]      last_q, last_d;
  logic [N-1:0]    res_q, res_d;
  logic            co_q, co_d;
  logic            dz_q, dz_d;
  logic [7:0]      rq;
  logic [2:0]      ops [8];
  logic [N-1:0]    as [8];
  logic [N-1:0]    bs [8];
  logic [2:0]      idx, win;
  logic            found;
  logic [CW-1:0]   win_cnt;
  // Unpack the requester buses into 8-entry arrays so a 3-bit index selects exactly.
  for (genvar g = 0; g < 8; g++) begin : g_unpack
    if (g < NREQ) begin : g_on
      assign rq[g]  = req[g];
      assign ops[g] = req_opcode[3*g +: 3];
      assign as[g]  = req_a[N*g +: N];
      assign bs[g]  = req_b[N*g +: N];
    end else begin : g_off
      assign rq[g]  = 1'b0;
      assign ops[g] = 3'd0;
      assign as[g]  = '0;
      assign bs[g]  = '0;
    end
  end
  always_comb begin
    win   = 3'd0;
    found = 1'b0;
    idx   = last_q;
    for (int k = 0; k < NREQ; k++) begin
      idx = (idx == 3'(NREQ - 1)) ? 3'd0 : idx + 3'd1;
      if (!found && rq[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    win_cnt = (ops[win] == 3'b010 || ops[win] == 3'b011) ? CW'(SLOW_LAT - 1) : CW'(FAST_LAT - 1);
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    gid_d   = gid_q;
    last_d  = last_q;
    res_d   = res_q;
    co_d    = co_q;
    dz_d    = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        op_d    = ops[win];
        a_d     = as[win];
        b_d     = bs[win];
        gid_d   = win;
        cnt_d   = win_cnt;
        state_d = EXEC;
`ifdef ALU_SHARE_DIVZERO_GUARD_EN
        if (ops[win] == 3'b011 && bs[win] == '0) begin
          state_d = DONE;
          res_d   = '0;
          co_d    = 1'b0;
          dz_d    = 1'b1;
        end
`endif
      end
      EXEC: if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        res_d   = alu_result;
        co_d    = alu_carryout;
        state_d = DONE;
      end
      DONE: begin
        last_d  = gid_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gid_q   <= '0;
      last_q  <= 3'(NREQ - 1);
      res_q   <= '0;
      co_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      res_q   <= res_d;
      co_q    <= co_d;
      dz_q    <= dz_d;
    end
  end
  assign ack        = {NREQ{state_q == DONE}} & (NREQ'(1) << gid_q);
  assign busy       = state_q != IDLE;
  assign result     = res_q;
  assign carryout   = co_q;
  assign grant_id   = gid_q;
  assign alu_opcode = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
`ifdef ALU_SHARE_DIVZERO_GUARD_EN
  assign div_zero   = dz_q;
`else
  logic unused_dz;
  assign unused_dz  = dz_q;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed bench for alu_share_arbiter with a behavioural ALU attached.
module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [5:0]  req_opcode;
  logic [63:0] req_a, req_b;
  logic [1:0]  ack;
  logic [31:0] result;
  logic        carryout;
  logic [2:0]  grant_id;
  logic        busy;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_carryout;
`ifdef ALU_SHARE_DIVZERO_GUARD_EN
  logic        div_zero;
`endif
  int total = 0;
  int bad = 0;

  alu_share_arbiter #(.N(32), .NREQ(2), .FAST_LAT(1), .SLOW_LAT(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .ack(ack), .result(result), .carryout(carryout), .grant_id(grant_id), .busy(busy),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_carryout(alu_carryout)
`ifdef ALU_SHARE_DIVZERO_GUARD_EN
    , .div_zero(div_zero)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result   = '0;
    alu_carryout = 1'b0;
    case (alu_opcode)
      3'd0: {alu_carryout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: {alu_carryout, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: alu_result = alu_a * alu_b;
      3'd3: alu_result = (alu_b == 0) ? alu_a : alu_a % alu_b;
      3'd4: alu_result = alu_a & alu_b;
      3'd5: alu_result = alu_a | alu_b;
      3'd6: alu_result = alu_a ^ alu_b;
      default: alu_result = ~alu_a;
    endcase
  end

  task automatic set_op(input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_opcode[3*id +: 3] = op;
    req_a[32*id +: 32]    = a;
    req_b[32*id +: 32]    = b;
  endtask

  task automatic wait_ack(output int n, output bit multi);
    n = 0;
    multi = 0;
    do begin
      @(negedge clk);
      n++;
      if ($countones(ack) > 1) multi = 1;
    end while (ack == 2'b00 && n < 20);
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++; if (ack !== 2'b00) begin bad++; $display("FAIL reset_ack got %b want 00", ack); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got %h want 0", result); end
    total++; if (carryout !== 1'b0) begin bad++; $display("FAIL reset_co got %b want 0", carryout); end
    total++; if (grant_id !== 3'd0) begin bad++; $display("FAIL reset_gid got %0d want 0", grant_id); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if ({alu_opcode, alu_a, alu_b} !== 67'd0) begin bad++; $display("FAIL reset_alu got %h/%h/%h want 0", alu_opcode, alu_a, alu_b); end
    rst = 1'b0;
  endtask

  task automatic test_add;
    set_op(0, 3'd0, 32'hFFFF_FFFF, 32'd1);
    req = 2'b01;
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL add_busy_exec got %b want 1", busy); end
    total++; if (ack !== 2'b00) begin bad++; $display("FAIL add_ack_exec got %b want 00", ack); end
    total++; if (alu_a !== 32'hFFFF_FFFF || alu_b !== 32'd1) begin bad++; $display("FAIL add_alu_in got %h/%h want ffffffff/1", alu_a, alu_b); end
    @(negedge clk);
    total++; if (ack !== 2'b01) begin bad++; $display("FAIL add_ack got %b want 01", ack); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL add_result got %h want 0", result); end
    total++; if (carryout !== 1'b1) begin bad++; $display("FAIL add_co got %b want 1", carryout); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL add_busy_done got %b want 1", busy); end
    req = 2'b00;
    @(negedge clk);
    total++; if (ack !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL add_idle got ack=%b busy=%b want 00/0", ack, busy); end
    total++; if (result !== 32'd0 || carryout !== 1'b1) begin bad++; $display("FAIL add_hold got %h/%b want 0/1", result, carryout); end
  endtask

  task automatic test_mul;
    int n;
    bit stable;
    set_op(1, 3'd2, 32'd7, 32'd6);
    req = 2'b10;
    n = 0;
    stable = 1;
    do begin
      @(negedge clk);
      n++;
      if (busy && ack == 2'b00 && (alu_opcode !== 3'd2 || alu_a !== 32'd7 || alu_b !== 32'd6)) stable = 0;
    end while (ack == 2'b00 && n < 20);
    total++; if (n != 5) begin bad++; $display("FAIL mul_latency got %0d want 5", n); end
    total++; if (ack !== 2'b10) begin bad++; $display("FAIL mul_ack got %b want 10", ack); end
    total++; if (result !== 32'd42 || carryout !== 1'b0) begin bad++; $display("FAIL mul_result got %0d/%b want 42/0", result, carryout); end
    total++; if (grant_id !== 3'd1) begin bad++; $display("FAIL mul_gid got %0d want 1", grant_id); end
    total++; if (!stable) begin bad++; $display("FAIL mul_alu_stable got 0 want 1"); end
    req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_contention;
    int n;
    bit multi;
    logic [1:0] exp_ack;
    set_op(0, 3'd0, 32'd1, 32'd1);
    set_op(1, 3'd0, 32'd1, 32'd1);
    req = 2'b11;
    for (int g = 0; g < 4; g++) begin
      wait_ack(n, multi);
      exp_ack = (g % 2 == 0) ? 2'b01 : 2'b10;
      total++; if (ack !== exp_ack) begin bad++; $display("FAIL rr_ack%0d got %b want %b", g, ack, exp_ack); end
      total++; if (grant_id !== 3'(g % 2)) begin bad++; $display("FAIL rr_gid%0d got %0d want %0d", g, grant_id, g % 2); end
      total++; if (result !== 32'd2) begin bad++; $display("FAIL rr_result%0d got %0d want 2", g, result); end
      total++; if (n != ((g == 0) ? 2 : 3)) begin bad++; $display("FAIL rr_interval%0d got %0d want %0d", g, n, (g == 0) ? 2 : 3); end
      total++; if (multi) begin bad++; $display("FAIL rr_onehot%0d got multi-hot want one-hot", g); end
    end
    req = 2'b00;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_stop got busy=%b want 0", busy); end
  endtask

  task automatic test_withdraw;
    set_op(0, 3'd1, 32'd10, 32'd3);
    req = 2'b01;
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wd_busy got %b want 1", busy); end
    req = 2'b00;
    @(negedge clk);
    total++; if (ack !== 2'b01) begin bad++; $display("FAIL wd_ack got %b want 01", ack); end
    total++; if (result !== 32'd7 || carryout !== 1'b0) begin bad++; $display("FAIL wd_result got %0d/%b want 7/0", result, carryout); end
    @(negedge clk);
    total++; if (ack !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL wd_idle got ack=%b busy=%b want 00/0", ack, busy); end
  endtask

  task automatic test_reset_midop;
    int n;
    bit multi;
    int acks;
    set_op(1, 3'd2, 32'd3, 32'd5);
    req = 2'b10;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || ack !== 2'b00) begin bad++; $display("FAIL rmid_state got busy=%b ack=%b want 0/00", busy, ack); end
    total++; if (result !== 32'd0 || carryout !== 1'b0 || grant_id !== 3'd0) begin bad++; $display("FAIL rmid_out got %h/%b/%0d want 0/0/0", result, carryout, grant_id); end
    total++; if ({alu_opcode, alu_a, alu_b} !== 67'd0) begin bad++; $display("FAIL rmid_alu got %h/%h/%h want 0", alu_opcode, alu_a, alu_b); end
    req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack != 2'b00) acks++;
    end
    total++; if (acks != 0) begin bad++; $display("FAIL rmid_noack got %0d acks want 0", acks); end
    set_op(1, 3'd0, 32'd2, 32'd3);
    req = 2'b10;
    wait_ack(n, multi);
    total++; if (n != 2 || ack !== 2'b10) begin bad++; $display("FAIL rmid_regrant got n=%0d ack=%b want 2/10", n, ack); end
    total++; if (result !== 32'd5 || grant_id !== 3'd1) begin bad++; $display("FAIL rmid_result got %0d/%0d want 5/1", result, grant_id); end
    req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_mod;
    int n;
    bit multi;
    set_op(0, 3'd3, 32'd17, 32'd5);
    req = 2'b01;
    wait_ack(n, multi);
    total++; if (n != 5 || ack !== 2'b01) begin bad++; $display("FAIL mod_latency got n=%0d ack=%b want 5/01", n, ack); end
    total++; if (result !== 32'd2) begin bad++; $display("FAIL mod_result got %0d want 2", result); end
`ifdef ALU_SHARE_DIVZERO_GUARD_EN
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL mod_dz got %b want 0", div_zero); end
`endif
    req = 2'b00;
    @(negedge clk);
    set_op(0, 3'd3, 32'd9, 32'd0);
    req = 2'b01;
    wait_ack(n, multi);
`ifdef ALU_SHARE_DIVZERO_GUARD_EN
    total++; if (n != 1 || ack !== 2'b01) begin bad++; $display("FAIL dz_latency got n=%0d ack=%b want 1/01", n, ack); end
    total++; if (result !== 32'd0 || carryout !== 1'b0 || div_zero !== 1'b1) begin bad++; $display("FAIL dz_out got %0d/%b/%b want 0/0/1", result, carryout, div_zero); end
    req = 2'b00;
    @(negedge clk);
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL dz_clear got %b want 0", div_zero); end
`else
    total++; if (n != 5 || ack !== 2'b01) begin bad++; $display("FAIL modz_latency got n=%0d ack=%b want 5/01", n, ack); end
    total++; if (result !== 32'd9) begin bad++; $display("FAIL modz_result got %0d want 9", result); end
    req = 2'b00;
    @(negedge clk);
`endif
  endtask

  task automatic test_logic;
    int n;
    bit multi;
    set_op(1, 3'd4, 32'h0000_F0F0, 32'h0000_FF00);
    req = 2'b10;
    wait_ack(n, multi);
    total++; if (n != 2 || ack !== 2'b10) begin bad++; $display("FAIL and_latency got n=%0d ack=%b want 2/10", n, ack); end
    total++; if (result !== 32'h0000_F000) begin bad++; $display("FAIL and_result got %h want 0000f000", result); end
    req = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req = 2'b00;
    req_opcode = '0;
    req_a = '0;
    req_b = '0;
    test_reset();
    test_add();
    test_mul();
    test_contention();
    test_withdraw();
    test_reset_midop();
    test_mod();
    test_logic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
